// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for configuration-chain loading.
package fpga_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_ld_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;

  // One serial step of CRC-16-CCITT, MSB-first feedback.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) feeding the chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader_crc16.sv
// Serial bit-in CRC-16-CCITT: clear loads the seed, enable folds in one bit.
module ccff_crc16
  import fpga_cfg_pkg::*;
(
  input  logic        prog_clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      crc_reg <= 16'h0000;
    end else if (clear) begin
      crc_reg <= CRC16_SEED;
    end else if (enable) begin
      crc_reg <= crc16_step(crc_reg, bit_in);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads one ccff configuration chain LSB-first from a valid/ready word stream.
// Optional CCFF_READBACK_EN adds a CRC-16 signature of the bits leaving the chain tail.
module ccff_chain_loader
  import fpga_cfg_pkg::*;
#(
  parameter int  CHAIN_LEN = 17,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 reset,
  input  logic                 start,
  ccff_chain_loader_if.slave   word_if,
  output logic                 ccff_head,
  output logic                 shift_en,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bit_count
`ifdef CCFF_READBACK_EN
  ,
  output logic [15:0]          readback_crc
`endif
);

  localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

  ccff_ld_state_e    state_reg, state_next;
  logic [WORD_W-1:0] sreg_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  idx_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              head_reg;

  logic start_accept;
  logic word_accept;
  logic in_shift;
  logic word_end;
  logic chain_full;

  assign start_accept = (state_reg == IDLE) && start;
  assign word_accept  = (state_reg == FETCH) && word_if.word_valid;
  assign in_shift     = (state_reg == SHIFT);
  assign word_end     = (idx_reg == LAST_IDX);
  // The bit on the head this cycle is the last one the chain needs.
  assign chain_full   = (cnt_reg == LAST_CNT);
  assign idx_next     = idx_reg + 1'b1;

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (start) state_next = FETCH;
      FETCH: if (word_if.word_valid) state_next = SHIFT;
      SHIFT: begin
        if (chain_full) begin
          state_next = DONE;
        end else if (word_end) begin
          state_next = FETCH;
        end
      end
      DONE:  state_next = IDLE;
    endcase
  end

  always_comb begin
    word_if.word_ready = (state_reg == FETCH);
    shift_en           = in_shift;
    busy               = (state_reg == FETCH) || (state_reg == SHIFT);
    done               = (state_reg == DONE);
  end

  // Head is registered so it holds its last value through bubbles and idle.
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      sreg_reg <= '0;
      idx_reg  <= '0;
      cnt_reg  <= '0;
      head_reg <= 1'b0;
    end else begin
      if (start_accept) begin
        cnt_reg <= '0;
      end
      if (word_accept) begin
        sreg_reg <= word_if.word_data;
        idx_reg  <= '0;
        head_reg <= word_if.word_data[0];
      end
      if (in_shift) begin
        idx_reg <= idx_next;
        if (cnt_reg != FULL_CNT) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (!word_end) begin
          head_reg <= sreg_reg[idx_next];
        end
      end
    end
  end

  assign ccff_head = head_reg;
  assign bit_count = cnt_reg;

`ifdef CCFF_READBACK_EN
  ccff_crc16 u_crc (
    .prog_clk (prog_clk),
    .reset    (reset),
    .clear    (start_accept),
    .enable   (in_shift),
    .bit_in   (ccff_tail),
    .crc      (readback_crc)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader with a queue-based bit scoreboard and chain model.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 17;

  logic        prog_clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic        ccff_head, shift_en, ccff_tail, busy, done;
  logic [4:0]  bit_count;
  logic        ccff_head8, shift_en8, busy8, done8;
  logic        tail8 = 1'b0;
  logic [3:0]  bit_count8;
  logic [15:0] readback_crc, readback_crc8;

  int errors = 0;
  int checks = 0;

  ccff_chain_loader_if #(.WORD_W(8)) bus ();
  ccff_chain_loader_if #(.WORD_W(8)) bus8 ();

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(17), .WORD_W(8)) u_dut (
    .prog_clk (prog_clk), .reset (reset), .start (start), .word_if (bus),
    .ccff_head (ccff_head), .shift_en (shift_en), .ccff_tail (ccff_tail),
    .busy (busy), .done (done), .bit_count (bit_count)
`ifdef CCFF_READBACK_EN
    , .readback_crc (readback_crc)
`endif
  );

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
    .prog_clk (prog_clk), .reset (reset), .start (start8), .word_if (bus8),
    .ccff_head (ccff_head8), .shift_en (shift_en8), .ccff_tail (tail8),
    .busy (busy8), .done (done8), .bit_count (bit_count8)
`ifdef CCFF_READBACK_EN
    , .readback_crc (readback_crc8)
`endif
  );

`ifndef CCFF_READBACK_EN
  assign readback_crc  = 16'h0000;
  assign readback_crc8 = 16'h0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_ref(input bit bits[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bits[i]) c = (c << 1) ^ ((c[15] ^ bits[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  // Behavioural chain: 17 flops, head enters at [0], tail leaves from [16].
  logic [16:0] chain;
  logic [16:0] preload_val;
  logic        preload_req;
  always @(posedge prog_clk) begin
    if (preload_req) chain <= preload_val;
    else if (shift_en) chain <= {chain[15:0], ccff_head};
  end
  assign ccff_tail = chain[16];

  // Scoreboard: bits owed to the chain, shifts made, load activity.
  bit          exp_q[$];
  bit          tail_q[$];
  bit          obs_q[$];
  int          m_shifts = 0;
  int          m_pushed = 0;
  bit          m_active = 0;
  bit          m_done   = 0;
  logic [15:0] crc_hold = 16'h0000;

  always @(negedge prog_clk) begin
    bit exp_shift;
    bit exp_ready;
    bit next_done;
    if (!reset) begin
      exp_q.delete();
      tail_q.delete();
      m_shifts = 0;
      m_pushed = 0;
      m_active = 0;
      m_done   = 0;
      crc_hold = 16'h0000;
    end else begin
      exp_shift = (exp_q.size() != 0);
      exp_ready = m_active && !exp_shift;
      check("shift_en", shift_en, exp_shift);
      check("word_ready", bus.word_ready, exp_ready);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("bit_count", bit_count, m_shifts);
`ifdef CCFF_READBACK_EN
      if (m_done) begin
        crc_hold = crc_ref(tail_q);
        check("readback_crc", readback_crc, crc_hold);
      end else if (!m_active) begin
        check("readback_hold", readback_crc, crc_hold);
      end
`endif
      next_done = 0;
      if (exp_shift) begin
        check("ccff_head", ccff_head, exp_q[0]);
        obs_q.push_back(ccff_head);
        tail_q.push_back(ccff_tail);
        void'(exp_q.pop_front());
        m_shifts++;
        if (m_shifts == CHAIN_LEN) begin
          m_active  = 0;
          next_done = 1;
        end
      end
      if (exp_ready && bus.word_valid) begin
        for (int i = 0; i < 8; i++) begin
          if (m_pushed < CHAIN_LEN) begin
            exp_q.push_back(bus.word_data[i]);
            m_pushed++;
          end
        end
      end
      if (start && !m_active && !m_done) begin
        m_active = 1;
        m_shifts = 0;
        m_pushed = 0;
        tail_q.delete();
      end
      m_done = next_done;
    end
  end

  logic [7:0] words_q[$];

  task automatic pulse_start();
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
  endtask

  task automatic drive_words(input int gap_min, input int gap_max);
    int budget;
    while (words_q.size() > 0) begin
      bus.word_data  = words_q[0];
      bus.word_valid = 1'b1;
      budget = 0;
      do begin
        @(negedge prog_clk);
        budget++;
      end while (!bus.word_ready && budget < 200);
      if (!bus.word_ready) begin
        check("word_handshake_timeout", bus.word_ready, 1);
        bus.word_valid = 1'b0;
        words_q.delete();
        return;
      end
      @(posedge prog_clk); #1;
      void'(words_q.pop_front());
      if (gap_max > 0 && words_q.size() > 0) begin
        bus.word_valid = 1'b0;
        bus.word_data  = 8'($urandom);
        repeat ($urandom_range(gap_max, gap_min)) @(posedge prog_clk);
        #1;
      end
    end
    bus.word_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge prog_clk); #1;
      n++;
    end while (!done && n < bound);
    check("done_reached", done, 1);
  endtask

  task automatic push_random_words();
    for (int i = 0; i < 3; i++) words_q.push_back(8'($urandom));
  endtask

  int lit_arr[17] = '{1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1};
  bit lit_q[$];
  bit pre_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p8, hs8, d8, ones8;
    reset = 1'b0; start = 1'b0; start8 = 1'b0;
    bus.word_valid = 1'b0; bus.word_data = 8'h00;
    bus8.word_valid = 1'b0; bus8.word_data = 8'h00;
    preload_req = 1'b0; preload_val = 17'h1ABCD;
    foreach (lit_arr[i]) lit_q.push_back(lit_arr[i][0]);
    for (int i = 16; i >= 0; i--) pre_q.push_back(preload_val[i]);

    repeat (2) @(posedge prog_clk);
    #1 preload_req = 1'b1;
    @(posedge prog_clk); #1 preload_req = 1'b0;
    check("rst_head", ccff_head, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_ready", bus.word_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_readback", readback_crc, 16'h0000);
    check("rst8_busy", busy8, 0);
    reset = 1'b1;
    repeat (2) @(posedge prog_clk);

    // Basic load against the literal head sequence.
    obs_q.delete();
    pulse_start();
    words_q = '{8'hA5, 8'h3C, 8'h01};
    drive_words(0, 0);
    wait_done(100);
    check("basic_pulses", obs_q.size(), 17);
    for (int i = 0; i < 17 && i < obs_q.size(); i++) check("basic_head_lit", obs_q[i], lit_q[i]);
    check("basic_bit_count", bit_count, 17);
`ifdef CCFF_READBACK_EN
    check("rb_preload", readback_crc, crc_ref(pre_q));
`endif

    // Backpressure: five idle cycles between words.
    pulse_start();
    push_random_words();
    drive_words(5, 5);
    wait_done(200);
`ifdef CCFF_READBACK_EN
    check("rb_second_load", readback_crc, crc_ref(lit_q));
`endif

    // word_valid while idle must be ignored.
    @(posedge prog_clk); #1;
    bus.word_valid = 1'b1;
    repeat (4) begin
      bus.word_data = 8'($urandom);
      @(posedge prog_clk); #1;
    end
    bus.word_valid = 1'b0;
    check("idle_bit_count", bit_count, 17);

    // start pulsed mid-load, then again during the done cycle.
    pulse_start();
    push_random_words();
    fork
      drive_words(0, 2);
      begin
        repeat (6) @(posedge prog_clk);
        #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
      end
    join
    n = 0;
    do begin
      @(negedge prog_clk); #1;
      n++;
    end while (!(shift_en && bit_count == 5'd16) && n < 100);
    check("last_shift_seen", shift_en, 1);
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    @(negedge prog_clk);
    check("start_in_done_ignored", busy, 0);
    check("abuse_bit_count", bit_count, 17);

    // Randomised loads with random gaps.
    for (int k = 0; k < 6; k++) begin
      pulse_start();
      push_random_words();
      drive_words(0, $urandom_range(4, 0));
      wait_done(300);
    end

    // Reset after nine bits, then a clean reload.
    pulse_start();
    push_random_words();
    void'(words_q.pop_back());
    drive_words(0, 0);
    n = 0;
    do begin
      @(negedge prog_clk); #1;
      n++;
    end while (m_shifts < 9 && n < 50);
    check("nine_bits_seen", m_shifts, 9);
    @(posedge prog_clk); #2 reset = 1'b0;
    #1;
    check("midrst_head", ccff_head, 0);
    check("midrst_shift_en", shift_en, 0);
    check("midrst_ready", bus.word_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bit_count", bit_count, 0);
    check("midrst_readback", readback_crc, 16'h0000);
    @(posedge prog_clk); #1 reset = 1'b1;
    repeat (2) @(posedge prog_clk);
    pulse_start();
    push_random_words();
    drive_words(0, 1);
    wait_done(200);
    check("reload_bit_count", bit_count, 17);

    // Boundary: 8-bit chain, one 0xFF word.
    p8 = 0; hs8 = 0; d8 = 0; ones8 = 0;
    bus8.word_data = 8'hFF;
    bus8.word_valid = 1'b1;
    @(posedge prog_clk); #1 start8 = 1'b1;
    @(posedge prog_clk); #1 start8 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge prog_clk);
      if (shift_en8) begin
        p8++;
        if (ccff_head8) ones8++;
      end
      if (bus8.word_ready && bus8.word_valid) hs8++;
      if (done8) d8++;
    end
    bus8.word_valid = 1'b0;
    check("b8_pulses", p8, 8);
    check("b8_ones", ones8, 8);
    check("b8_fetches", hs8, 1);
    check("b8_done", d8, 1);
    check("b8_idle", busy8, 0);
    check("b8_bit_count", bit_count8, 8);

    repeat (3) @(posedge prog_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
